wbu: RTL and testbench
======================

WBU -- requirements
Module: wbu

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  upstream execute result valid.
REQ-004 SHALL have port in_ready  output  1  wbu can accept a result this cycle.
REQ-005 SHALL have port exu_data  input  32  execute result: ALU value, jump target, or compare code (0 equal, 32'b10 greater, 32'b100 less).
REQ-006 SHALL have port wb_op  input  2  00 ALU write, 01 branch, 10 jump-and-link, 11 reserved.
REQ-007 SHALL have port br_cond  input  2  00 eq, 01 ne, 10 lt, 11 ge; signedness is already resolved upstream.
REQ-008 SHALL have port pc  input  32  PC of the instruction.
REQ-009 SHALL have port imm  input  32  branch offset.
REQ-010 SHALL have port rd  input  5  destination register.
REQ-011 SHALL have port gpr_wen, gpr_waddr, gpr_wdata  output  1/5/32  register-file write port.
REQ-012 SHALL have port npc_valid, npc_ready  output/input  1/1  next-PC handshake to fetch.
REQ-013 SHALL have port npc  output  32  next PC.
REQ-014 SHALL have port retired  output  32  committed-instruction counter.
REQ-015 SHALL have port err  output  1  sticky error flag.

Function
REQ-016 SHALL implement FSM states IDLE, COMMIT, HOLD.
REQ-017 SHALL drive in_ready=1 only in IDLE.
REQ-018 SHALL, in IDLE with in_valid=1, latch all input fields at the clock edge and enter COMMIT.
REQ-019 SHALL, in COMMIT, assert gpr_wen for exactly that one cycle when the op writes and the latched rd!=0.
REQ-020 SHALL drive npc_valid=1 in COMMIT and HOLD, and 0 in IDLE.
REQ-021 SHALL, in COMMIT, go to IDLE if npc_ready=1, else go to HOLD.
REQ-022 SHALL, in HOLD, keep gpr_wen=0, keep npc stable, and go to IDLE on npc_ready=1.
REQ-023 SHALL have a latency of one cycle: an input accepted at edge N gives gpr write and npc_valid in cycle N+1; peak throughput is one result per 2 cycles.
REQ-024 SHALL handle op 00: gpr_wdata=exu_data, npc=pc+4.
REQ-025 SHALL handle op 01: no write; npc=pc+imm if taken, else pc+4.
REQ-026 SHALL evaluate branches as taken for eq when code==0, ne when code!=0, lt when code==4, ge when code==0 or code==2.
REQ-027 SHALL handle op 10: gpr_wdata=pc+4, npc={exu_data[31:1],1'b0}.
REQ-028 SHALL handle op 11: no write, npc=pc+4, err set.
REQ-029 SHALL, on a branch whose compare code is not 0, 2 or 4, take no branch, set npc=pc+4 and set err.
REQ-030 SHALL perform all PC arithmetic modulo 2^32, wrapping silently.
REQ-031 SHALL increment retired by 1 on each npc_valid&npc_ready cycle, wrapping from 0xFFFFFFFF to 0.
REQ-032 SHALL hold err at 1 once set, until reset.
REQ-033 SHALL ignore in_valid outside IDLE; upstream holds its data until the handshake completes.

Reset
REQ-034 SHALL, on rst_n=0 at any time including mid-COMMIT or HOLD, immediately go to IDLE with gpr_wen=0, npc_valid=0, npc=0, gpr_waddr=0, gpr_wdata=0, retired=0, err=0, in_ready=1 after release.
REQ-035 SHALL NOT issue a write or handshake for a transaction interrupted by reset.

Verification
REQ-036 SHALL be verified for ALU write: op00, rd=5, exu_data=0x1234, pc=0x80000000 -> next cycle gpr_wen=1, waddr=5, wdata=0x1234, npc=0x80000004, retired=1.
REQ-037 SHALL be verified for a taken branch: op01, cond lt, exu_data=4, pc=0x100, imm=0xFFFFFFF0 -> npc=0xF0, gpr_wen=0.
REQ-038 SHALL be verified for jump-and-link with backpressure: op10, rd=1, exu_data=0x2003, pc=0x40, npc_ready=0 for 3 cycles -> one gpr_wen pulse with wdata=0x44, npc=0x2002 held stable through HOLD, in_ready=0 until the handshake completes.
REQ-039 SHALL be verified for rd=0: op00, rd=0 -> gpr_wen stays 0 and npc=pc+4.
REQ-040 SHALL be verified for a bad code: op01, cond eq, exu_data=6 -> not taken, err=1, and err stays 1 after later valid instructions.
REQ-041 SHALL be verified for reset in HOLD: rst_n low -> npc_valid=0, retired=0, and no write after release.

Source files
------------

// File: rtl/wbu.sv
// Write-back unit: commits one execute result per transaction, writes the register file
// and hands the next PC to fetch through a valid/ready handshake.
module wbu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] exu_data,
  input  logic [1:0]  wb_op,
  input  logic [1:0]  br_cond,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        npc_valid,
  input  logic        npc_ready,
  output logic [31:0] npc,
  output logic [31:0] retired,
  output logic        err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COMMIT = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_JAL = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  waddr_q;
  logic        wr_q, wr_d;
  logic        bad_d;
  logic        err_q;
  logic [31:0] retired_q;
  logic [31:0] pc_inc;
  logic        accept;

  // Compare codes from execute: 0 equal, 2 greater, 4 less; anything else is malformed.
  function automatic logic code_ok(input logic [31:0] code);
    return (code == 32'd0) || (code == 32'd2) || (code == 32'd4);
  endfunction

  function automatic logic br_taken(input logic [1:0] cond, input logic [31:0] code);
    logic t;
    case (cond)
      2'b00:   t = (code == 32'd0);
      2'b01:   t = (code != 32'd0);
      2'b10:   t = (code == 32'd4);
      default: t = (code == 32'd0) || (code == 32'd2);
    endcase
    return t;
  endfunction

  assign accept = (state_q == IDLE) && in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = COMMIT;
      COMMIT:  state_d = npc_ready ? IDLE : HOLD;
      HOLD:    if (npc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results are computed from the live inputs and captured on the accepting edge,
  // so COMMIT and HOLD only replay registered values.
  always_comb begin
    pc_inc  = pc + 32'd4;
    npc_d   = pc_inc;
    wdata_d = exu_data;
    wr_d    = 1'b0;
    bad_d   = 1'b0;
    case (wb_op)
      OP_ALU: wr_d = (rd != 5'd0);
      OP_BR: begin
        if (!code_ok(exu_data)) bad_d = 1'b1;
        else if (br_taken(br_cond, exu_data)) npc_d = pc + imm;
      end
      OP_JAL: begin
        wr_d    = (rd != 5'd0);
        wdata_d = pc_inc;
        npc_d   = {exu_data[31:1], 1'b0};
      end
      default: bad_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      npc_q     <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        npc_q   <= npc_d;
        wdata_q <= wdata_d;
        waddr_q <= rd;
        wr_q    <= wr_d;
        err_q   <= err_q | bad_d;
      end
      if (npc_valid && npc_ready) retired_q <= retired_q + 32'd1;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign npc_valid = (state_q != IDLE);
  assign gpr_wen   = (state_q == COMMIT) && wr_q;
  assign gpr_waddr = waddr_q;
  assign gpr_wdata = wdata_q;
  assign npc       = npc_q;
  assign retired   = retired_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: directed scenarios plus randomized transactions checked against
// a transaction-level reference model.
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] exu_data = '0;
  logic [1:0]  wb_op = '0;
  logic [1:0]  br_cond = '0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [4:0]  rd = '0;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        npc_valid;
  logic        npc_ready = 1'b0;
  logic [31:0] npc;
  logic [31:0] retired;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret = '0;
  logic        exp_err = 1'b0;

  wbu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exu_data(exu_data), .wb_op(wb_op), .br_cond(br_cond), .pc(pc), .imm(imm), .rd(rd),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .npc_valid(npc_valid), .npc_ready(npc_ready), .npc(npc), .retired(retired), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Architectural outcome of one instruction.
  task automatic model(input logic [1:0] op, input logic [1:0] cond, input logic [31:0] exu,
                       input logic [31:0] pcv, input logic [31:0] immv, input logic [4:0] rdv,
                       output logic wr, output logic [31:0] wd, output logic [31:0] nn,
                       output logic e);
    logic t;
    wr = 1'b0; wd = '0; nn = pcv + 32'd4; e = 1'b0; t = 1'b0;
    case (op)
      2'b00: begin wr = (rdv != 0); wd = exu; end
      2'b01: begin
        if (exu != 0 && exu != 2 && exu != 4) e = 1'b1;
        else begin
          if (cond == 2'b00) t = (exu == 0);
          if (cond == 2'b01) t = (exu != 0);
          if (cond == 2'b10) t = (exu == 4);
          if (cond == 2'b11) t = (exu == 0 || exu == 2);
          if (t) nn = pcv + immv;
        end
      end
      2'b10: begin wr = (rdv != 0); wd = pcv + 32'd4; nn = exu & 32'hFFFF_FFFE; end
      default: e = 1'b1;
    endcase
  endtask

  task automatic txn(input string tag, input logic [1:0] op, input logic [1:0] cond,
                     input logic [31:0] exu, input logic [31:0] pcv, input logic [31:0] immv,
                     input logic [4:0] rdv, input int hold);
    logic wr, e;
    logic [31:0] wd, nn;
    model(op, cond, exu, pcv, immv, rdv, wr, wd, nn, e);
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    wb_op = op; br_cond = cond; exu_data = exu; pc = pcv; imm = immv; rd = rdv;
    in_valid = 1'b1; npc_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble the inputs: the unit must work from what it latched.
    in_valid = 1'b0;
    exu_data = $urandom; pc = $urandom; imm = $urandom; rd = 5'($urandom);
    wb_op = 2'($urandom); br_cond = 2'($urandom);
    exp_err = exp_err | e;
    for (int c = 0; c <= hold; c++) begin
      if (c == 1) in_valid = 1'b1;
      npc_ready = (c == hold);
      chk({tag, ".wen"}, 32'(gpr_wen), 32'((c == 0) && wr));
      if (c == 0 && wr) begin
        chk({tag, ".waddr"}, 32'(gpr_waddr), 32'(rdv));
        chk({tag, ".wdata"}, gpr_wdata, wd);
      end
      chk({tag, ".npc_valid"}, 32'(npc_valid), 32'd1);
      chk({tag, ".npc"}, npc, nn);
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      chk({tag, ".err"}, 32'(err), 32'(exp_err));
      chk({tag, ".retired"}, retired, exp_ret);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; npc_ready = 1'b0;
    exp_ret = exp_ret + 32'd1;
    chk({tag, ".retired_after"}, retired, exp_ret);
    chk({tag, ".npc_valid_after"}, 32'(npc_valid), 32'd0);
    chk({tag, ".wen_after"}, 32'(gpr_wen), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".wen"}, 32'(gpr_wen), 32'd0);
    chk({tag, ".npc_valid"}, 32'(npc_valid), 32'd0);
    chk({tag, ".npc"}, npc, 32'd0);
    chk({tag, ".waddr"}, 32'(gpr_waddr), 32'd0);
    chk({tag, ".wdata"}, gpr_wdata, 32'd0);
    chk({tag, ".retired"}, retired, 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
  endtask

  // Accept a write instruction, stall `stall` cycles, then pull reset asynchronously.
  task automatic reset_mid(input string tag, input int stall);
    wb_op = 2'b10; rd = 5'd3; exu_data = 32'h0000_3000; pc = 32'h200; imm = '0;
    in_valid = 1'b1; npc_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < stall; c++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 check_reset_state({tag, ".in_reset"});
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = '0; exp_err = 1'b0;
    npc_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk({tag, ".no_wen"}, 32'(gpr_wen), 32'd0);
      chk({tag, ".no_valid"}, 32'(npc_valid), 32'd0);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".retired"}, retired, 32'd0);
    end
    npc_ready = 1'b0;
  endtask

  task automatic random_batch(input string tag, input int n);
    logic [1:0] op;
    logic [31:0] exu, pcv;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: exu = 32'd0;
        1: exu = 32'd2;
        2: exu = 32'd4;
        default: exu = $urandom;
      endcase
      pcv = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      txn(tag, op, 2'($urandom), exu, pcv, $urandom, 5'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #2 check_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    txn("alu", 2'b00, 2'b00, 32'h1234, 32'h8000_0000, 32'h0, 5'd5, 0);
    chk("alu.retired_is_1", retired, 32'd1);
    txn("br_lt_taken", 2'b01, 2'b10, 32'd4, 32'h100, 32'hFFFF_FFF0, 5'd7, 0);
    txn("jal_bp", 2'b10, 2'b00, 32'h2003, 32'h40, 32'h0, 5'd1, 3);
    txn("rd0", 2'b00, 2'b00, 32'hDEAD_BEEF, 32'h500, 32'h0, 5'd0, 1);
    txn("pc_wrap", 2'b00, 2'b00, 32'h1, 32'hFFFF_FFFC, 32'h0, 5'd9, 0);
    txn("br_ge_eq", 2'b01, 2'b11, 32'd0, 32'h1000, 32'h20, 5'd0, 1);
    txn("br_ne_nt", 2'b01, 2'b01, 32'd0, 32'h1000, 32'h20, 5'd0, 0);
    txn("jal_rd0", 2'b10, 2'b00, 32'h7FFF, 32'h300, 32'h0, 5'd0, 0);
    chk("err_clear_before_bad", 32'(err), 32'd0);

    random_batch("randA", 30);

    txn("bad_code", 2'b01, 2'b00, 32'd6, 32'h600, 32'h40, 5'd0, 0);
    chk("bad_code.err", 32'(err), 32'd1);
    txn("after_bad_alu", 2'b00, 2'b00, 32'h55, 32'h700, 32'h0, 5'd4, 0);
    txn("after_bad_br", 2'b01, 2'b00, 32'd0, 32'h700, 32'h10, 5'd0, 2);
    chk("err_sticky", 32'(err), 32'd1);
    txn("reserved", 2'b11, 2'b00, 32'h0, 32'h800, 32'h0, 5'd6, 0);

    reset_mid("rst_hold", 2);
    reset_mid("rst_commit", 0);

    random_batch("randB", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
